lvds_frame_align: RTL and testbench

LVDS_FRAME_ALIGN -- requirements
Module: lvds_frame_align

---
 rtl/lvds_align_pkg.sv | 22 ++
 rtl/lvds_frame_align_if.sv | 29 ++
 rtl/lvds_lane_interleave.sv | 19 +
 rtl/lvds_frame_align.sv | 165 ++++++++++++++++
 tb/tb_lvds_frame_align.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lvds_align_pkg.sv
// Shared FSM state encoding and default alignment constants for lvds_frame_align.
package lvds_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  localparam logic [7:0]  DEF_FRAME_PAT = 8'hF0;
  localparam int unsigned DEF_SETTLE    = 10;
  localparam int unsigned DEF_LOCK_CNT  = 4;
  localparam int unsigned DEF_LOSS_CNT  = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lvds_frame_align_if.sv
// Bundle of the frame/lane data, control and status signals of lvds_frame_align.
interface lvds_frame_align_if #(
  parameter int unsigned N_CH  = 1,
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 8
);
  localparam int unsigned SW = $clog2(DW) + 1;

  logic [DW-1:0]            frame_data;
  logic [N_CH*LANES*DW-1:0] lane_data;
  logic                     align_start;
  logic                     bitslip;
  logic [N_CH*LANES*DW-1:0] sample_out;
  logic                     sample_valid;
  logic                     locked;
  logic                     align_fail;
  logic [SW-1:0]            slip_count;
  logic [15:0]              err_cnt;

  modport master (
    output frame_data, lane_data, align_start,
    input  bitslip, sample_out, sample_valid, locked, align_fail, slip_count, err_cnt
  );

  modport slave (
    input  frame_data, lane_data, align_start,
    output bitslip, sample_out, sample_valid, locked, align_fail, slip_count, err_cnt
  );
endinterface

// File: rtl/lvds_lane_interleave.sv
// Reassembles one channel's lanes into a sample, bits taken MSB-first round-robin across lanes.
module lvds_lane_interleave #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 8
) (
  input  logic [LANES*DW-1:0] i_lanes,
  output logic [LANES*DW-1:0] o_sample
);

  always_comb begin
    o_sample = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        o_sample[LANES*DW-1-(i*LANES+l)] = i_lanes[l*DW + DW-1-i];
      end
    end
  end

endmodule

// File: rtl/lvds_frame_align.sv
// Frame-clock bitslip alignment FSM with lock/loss tracking and per-channel sample reassembly.
module lvds_frame_align
  import lvds_align_pkg::*;
#(
  parameter int unsigned    N_CH      = 1,
  parameter int unsigned    LANES     = 2,
  parameter int unsigned    DW        = 8,
  parameter logic [DW-1:0]  FRAME_PAT = DW'(DEF_FRAME_PAT),
  parameter int unsigned    SETTLE    = DEF_SETTLE,
  parameter int unsigned    LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned    LOSS_CNT  = DEF_LOSS_CNT
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [DW-1:0]               frame_data,
  input  logic [N_CH*LANES*DW-1:0]    lane_data,
  input  logic                        align_start,
  output logic                        bitslip,
  output logic [N_CH*LANES*DW-1:0]    sample_out,
  output logic                        sample_valid,
  output logic                        locked,
  output logic                        align_fail,
  output logic [$clog2(DW):0]         slip_count,
  output logic [15:0]                 err_cnt
);

  localparam int unsigned SW = $clog2(DW) + 1;
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);
  localparam int unsigned WW = $clog2(SETTLE + 1);

  lvds_frame_align_if #(.N_CH(N_CH), .LANES(LANES), .DW(DW)) u_bus ();

  state_t                   r_state, w_next;
  logic [SW-1:0]            r_slip_cnt;
  logic [MW-1:0]            r_match_cnt;
  logic [LW-1:0]            r_loss_cnt;
  logic [WW-1:0]            r_wait_cnt;
  logic [15:0]              r_err_cnt;
  logic [N_CH*LANES*DW-1:0] r_sample, w_sample;
  logic                     r_sample_valid;
  logic                     w_match, w_lock_hit, w_loss_hit, w_settled, w_slip_max;
  logic                     w_bitslip, w_locked, w_align_fail;

  assign u_bus.frame_data  = frame_data;
  assign u_bus.lane_data   = lane_data;
  assign u_bus.align_start = align_start;

  assign w_match    = (u_bus.frame_data == FRAME_PAT);
  assign w_lock_hit = (r_match_cnt == MW'(LOCK_CNT - 1));
  assign w_loss_hit = (r_loss_cnt == LW'(LOSS_CNT - 1));
  assign w_settled  = (r_wait_cnt == WW'(SETTLE - 1));
  assign w_slip_max = (r_slip_cnt == SW'(DW - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (u_bus.align_start) begin
      w_next = ST_CHECK;
    end else begin
      case (r_state)
        ST_CHECK: begin
          if (w_match) begin
            if (w_lock_hit) w_next = ST_LOCKED;
          end else begin
            w_next = w_slip_max ? ST_FAIL : ST_SLIP;
          end
        end
        ST_SLIP:   w_next = ST_WAIT;
        ST_WAIT:   if (w_settled) w_next = ST_CHECK;
        ST_LOCKED: if (!w_match && w_loss_hit) w_next = ST_CHECK;
        ST_IDLE, ST_FAIL: w_next = r_state;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state, so a reset edge silences bitslip immediately.
  always_comb begin
    w_bitslip    = (r_state == ST_SLIP);
    w_locked     = (r_state == ST_LOCKED);
    w_align_fail = (r_state == ST_FAIL);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_slip_cnt  <= '0;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_err_cnt   <= '0;
    end else if (u_bus.align_start) begin
      r_slip_cnt  <= '0;
      r_match_cnt <= '0;
      r_loss_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CHECK: begin
          r_loss_cnt  <= '0;
          r_match_cnt <= (w_match && !w_lock_hit) ? r_match_cnt + MW'(1) : '0;
        end
        ST_SLIP: begin
          r_slip_cnt <= r_slip_cnt + SW'(1);
          r_wait_cnt <= '0;
        end
        ST_WAIT: r_wait_cnt <= w_settled ? '0 : r_wait_cnt + WW'(1);
        ST_LOCKED: begin
          if (w_match) begin
            r_loss_cnt <= '0;
          end else begin
            r_err_cnt <= sat_inc16(r_err_cnt);
            if (w_loss_hit) begin
              r_loss_cnt  <= '0;
              r_slip_cnt  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_loss_cnt <= r_loss_cnt + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lvds_lane_interleave #(.LANES(LANES), .DW(DW)) u_il (
      .i_lanes  (u_bus.lane_data[c*LANES*DW +: LANES*DW]),
      .o_sample (w_sample[c*LANES*DW +: LANES*DW])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample       <= w_sample;
      r_sample_valid <= w_locked;
    end
  end

  assign u_bus.bitslip      = w_bitslip;
  assign u_bus.locked       = w_locked;
  assign u_bus.align_fail   = w_align_fail;
  assign u_bus.slip_count   = r_slip_cnt;
  assign u_bus.err_cnt      = r_err_cnt;
  assign u_bus.sample_out   = r_sample;
  assign u_bus.sample_valid = r_sample_valid;

  assign bitslip      = u_bus.bitslip;
  assign locked       = u_bus.locked;
  assign align_fail   = u_bus.align_fail;
  assign slip_count   = u_bus.slip_count;
  assign err_cnt      = u_bus.err_cnt;
  assign sample_out   = u_bus.sample_out;
  assign sample_valid = u_bus.sample_valid;

endmodule

// File: tb/tb_lvds_frame_align.sv
// Directed bench for lvds_frame_align: vector table for sample reassembly plus alignment sequences.
module tb_lvds_frame_align;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   pulses   = 0;
  int   cyc      = 0;
  int   last_p   = 0;
  int   min_gap  = 100000;
  logic       model_en = 1'b0;
  logic [7:0] base     = 8'h00;
  int         p0       = 0;

  lvds_frame_align_if #(.N_CH(2), .LANES(2), .DW(8)) bus ();

  lvds_frame_align #(.N_CH(2), .LANES(2), .DW(8)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .frame_data   (bus.frame_data),
    .lane_data    (bus.lane_data),
    .align_start  (bus.align_start),
    .bitslip      (bus.bitslip),
    .sample_out   (bus.sample_out),
    .sample_valid (bus.sample_valid),
    .locked       (bus.locked),
    .align_fail   (bus.align_fail),
    .slip_count   (bus.slip_count),
    .err_cnt      (bus.err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle pulse monitor: counts bitslip pulses and the tightest spacing between them.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.bitslip === 1'b1) begin
      if (pulses > 0 && (cyc - last_p) < min_gap) min_gap = cyc - last_p;
      last_p = cyc;
      pulses = pulses + 1;
    end
  end

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < (n % 8); k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (model_en) bus.frame_data = rotl8(base, pulses - p0);
  endtask

  typedef struct {
    logic [31:0] lanes;
    logic [31:0] exp_sample;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h7C6B_0000, 32'h3DDA_0000};
    vecs[1] = '{32'hFF00_00FF, 32'h5555_AAAA};
    vecs[2] = '{32'hF00F_0FF0, 32'h55AA_AA55};
    vecs[3] = '{32'h8001_0180, 32'h4002_8001};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst_n           = 1'b0;
    bus.frame_data  = 8'hF0;
    bus.lane_data   = 32'hA5A5_5A5A;
    bus.align_start = 1'b0;
    repeat (3) tick();
    check("rst_bitslip",   {63'd0, bus.bitslip},      64'd0);
    check("rst_locked",    {63'd0, bus.locked},       64'd0);
    check("rst_fail",      {63'd0, bus.align_fail},   64'd0);
    check("rst_valid",     {63'd0, bus.sample_valid}, 64'd0);
    check("rst_slip_cnt",  {60'd0, bus.slip_count},   64'd0);
    check("rst_err_cnt",   {48'd0, bus.err_cnt},      64'd0);
    check("rst_sample",    {32'd0, bus.sample_out},   64'd0);
    rst_n = 1'b1;
    tick();

    // Already-aligned frame: lock after four matches with no slips.
    p0 = pulses;
    bus.align_start = 1'b1;
    tick();
    bus.align_start = 1'b0;
    check("a_not_locked_c1", {63'd0, bus.locked}, 64'd0);
    repeat (3) tick();
    check("a_not_locked_c4", {63'd0, bus.locked}, 64'd0);
    tick();
    check("a_locked_c5",     {63'd0, bus.locked}, 64'd1);
    check("a_slip_cnt",      {60'd0, bus.slip_count}, 64'd0);
    check("a_no_pulses",     64'(pulses - p0), 64'd0);
    tick();
    check("a_valid",         {63'd0, bus.sample_valid}, 64'd1);

    for (int v = 0; v < 5; v++) begin
      bus.lane_data = vecs[v].lanes;
      tick();
      check($sformatf("vec%0d_sample", v), {32'd0, bus.sample_out}, {32'd0, vecs[v].exp_sample});
      check($sformatf("vec%0d_valid", v),  {63'd0, bus.sample_valid}, 64'd1);
    end

    // Single bad frame is tolerated; two in a row drop lock.
    bus.frame_data = 8'h00;
    tick();
    bus.frame_data = 8'hF0;
    tick();
    check("loss1_locked", {63'd0, bus.locked}, 64'd1);
    check("loss1_err",    {48'd0, bus.err_cnt}, 64'd1);
    bus.frame_data = 8'h00;
    repeat (2) tick();
    bus.frame_data = 8'hF0;
    check("loss2_locked", {63'd0, bus.locked}, 64'd0);
    check("loss2_err",    {48'd0, bus.err_cnt}, 64'd3);
    repeat (4) tick();
    check("relock",       {63'd0, bus.locked}, 64'd1);
    check("relock_err",   {48'd0, bus.err_cnt}, 64'd3);

    // Deserializer model three slips away from the frame pattern.
    base = 8'h1E;
    p0 = pulses;
    model_en = 1'b1;
    bus.frame_data = rotl8(base, 0);
    bus.align_start = 1'b1;
    tick();
    bus.align_start = 1'b0;
    for (int i = 0; i < 300 && !bus.locked; i++) tick();
    check("b_locked",   {63'd0, bus.locked}, 64'd1);
    check("b_pulses",   64'(pulses - p0), 64'd3);
    check("b_slip_cnt", {60'd0, bus.slip_count}, 64'd3);
    check("b_gap_ok",   {63'd0, (min_gap >= 12)}, 64'd1);
    check("b_err_clr",  {48'd0, bus.err_cnt}, 64'd0);
    model_en = 1'b0;

    // Pattern never found: seven slips then fail.
    bus.frame_data = 8'h00;
    p0 = pulses;
    bus.align_start = 1'b1;
    tick();
    bus.align_start = 1'b0;
    for (int i = 0; i < 300 && !bus.align_fail; i++) tick();
    check("c_fail",     {63'd0, bus.align_fail}, 64'd1);
    check("c_locked",   {63'd0, bus.locked}, 64'd0);
    check("c_pulses",   64'(pulses - p0), 64'd7);
    check("c_slip_cnt", {60'd0, bus.slip_count}, 64'd7);
    repeat (30) tick();
    check("c_no_more",  64'(pulses - p0), 64'd7);
    check("c_fail_hold", {63'd0, bus.align_fail}, 64'd1);
    check("c_gap_ok",   {63'd0, (min_gap >= 12)}, 64'd1);
    bus.frame_data = 8'hF0;
    bus.align_start = 1'b1;
    tick();
    bus.align_start = 1'b0;
    check("c_fail_clr", {63'd0, bus.align_fail}, 64'd0);
    repeat (4) tick();
    check("c_relock",   {63'd0, bus.locked}, 64'd1);
    check("c_slip_clr", {60'd0, bus.slip_count}, 64'd0);

    // Reset during WAIT aborts alignment for good.
    bus.frame_data = 8'h00;
    p0 = pulses;
    bus.align_start = 1'b1;
    tick();
    bus.align_start = 1'b0;
    for (int i = 0; i < 20 && (pulses - p0) < 1; i++) tick();
    check("d_first_pulse", 64'(pulses - p0), 64'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("d_bitslip",  {63'd0, bus.bitslip},      64'd0);
    check("d_locked",   {63'd0, bus.locked},       64'd0);
    check("d_fail",     {63'd0, bus.align_fail},   64'd0);
    check("d_valid",    {63'd0, bus.sample_valid}, 64'd0);
    check("d_slip_cnt", {60'd0, bus.slip_count},   64'd0);
    check("d_err_cnt",  {48'd0, bus.err_cnt},      64'd0);
    check("d_sample",   {32'd0, bus.sample_out},   64'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("d_no_pulse", 64'(pulses - p0), 64'd1);
    check("d_idle_fail", {63'd0, bus.align_fail}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
